compound_assign_unit: RTL and testbench

//   Sequential executor for SystemVerilog compound-assignment operators (+= -= *= /= %= &= |= ^= <<= <<<= >>= >>>=).

---
 rtl/compound_assign_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_compound_assign_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compound_assign_unit.sv
// compound_assign_unit: sequential executor for SystemVerilog compound-assignment
// operators on a signed WIDTH-bit accumulator. Each accepted request applies one
// operator with its operand and returns the new accumulator value.
// Optional feature macro: COMPOUND_ASSIGN_DIV_EN enables the iterative
// restoring divider for DIV/MOD. Without it, ops 3/4 are answered as illegal.
module compound_assign_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_operand,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc_o
);

`ifdef COMPOUND_ASSIGN_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1
    } state_t;
`endif

    // Shift amounts at or beyond this value push every data bit out.
    localparam logic [WIDTH-1:0] WIDTH_U = WIDTH'(WIDTH);

    state_t           state_r;
    logic             accept_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_err_s;
    logic             start_div_s;

`ifdef COMPOUND_ASSIGN_DIV_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_mod_r;
    logic             q_neg_r;
    logic             r_neg_r;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             fits_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] q_final_s;
    logic [WIDTH-1:0] r_final_s;
    logic [WIDTH-1:0] div_res_s;
    logic [WIDTH-1:0] acc_mag_s;
    logic [WIDTH-1:0] opd_mag_s;
`endif

    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;

    // Single-cycle operator result, error detection and divide start decision.
    always_comb begin
        alu_res_s   = acc_o;
        alu_err_s   = 1'b0;
        start_div_s = 1'b0;
        case (req_op)
            4'd0:  alu_res_s = acc_o + req_operand;
            4'd1:  alu_res_s = acc_o - req_operand;
            4'd2:  alu_res_s = acc_o * req_operand;
            4'd3, 4'd4: begin
`ifdef COMPOUND_ASSIGN_DIV_EN
                if (req_operand == {WIDTH{1'b0}}) begin
                    alu_err_s = 1'b1;
                end else begin
                    start_div_s = 1'b1;
                end
`else
                alu_err_s = 1'b1;
`endif
            end
            4'd5:  alu_res_s = acc_o & req_operand;
            4'd6:  alu_res_s = acc_o | req_operand;
            4'd7:  alu_res_s = acc_o ^ req_operand;
            4'd8, 4'd9: begin
                if (req_operand >= WIDTH_U) begin
                    alu_res_s = {WIDTH{1'b0}};
                end else begin
                    alu_res_s = acc_o << req_operand;
                end
            end
            4'd10: begin
                if (req_operand >= WIDTH_U) begin
                    alu_res_s = {WIDTH{1'b0}};
                end else begin
                    alu_res_s = acc_o >> req_operand;
                end
            end
            4'd11: begin
                if (req_operand >= WIDTH_U) begin
                    alu_res_s = {WIDTH{acc_o[WIDTH-1]}};
                end else begin
                    alu_res_s = $unsigned($signed(acc_o) >>> req_operand);
                end
            end
            4'd12: alu_res_s = req_operand;
            default: alu_err_s = 1'b1;
        endcase
    end

`ifdef COMPOUND_ASSIGN_DIV_EN
    // Operand magnitudes plus one restoring-divide step; the final step also applies signs.
    always_comb begin
        if (acc_o[WIDTH-1]) begin
            acc_mag_s = -acc_o;
        end else begin
            acc_mag_s = acc_o;
        end
        if (req_operand[WIDTH-1]) begin
            opd_mag_s = -req_operand;
        end else begin
            opd_mag_s = req_operand;
        end
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        fits_s    = ~trial_s[WIDTH];
        if (fits_s) begin
            rem_next_s = trial_s[WIDTH-1:0];
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], fits_s};
        if (q_neg_r) begin
            q_final_s = -quo_next_s;
        end else begin
            q_final_s = quo_next_s;
        end
        if (r_neg_r) begin
            r_final_s = -rem_next_s;
        end else begin
            r_final_s = rem_next_s;
        end
        if (is_mod_r) begin
            div_res_s = r_final_s;
        end else begin
            div_res_s = q_final_s;
        end
    end
`endif

    // Control FSM with registered response and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            acc_o     <= {WIDTH{1'b0}};
            rsp_acc   <= {WIDTH{1'b0}};
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b0;
`ifdef COMPOUND_ASSIGN_DIV_EN
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            is_mod_r <= 1'b0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && start_div_s) begin
`ifdef COMPOUND_ASSIGN_DIV_EN
                        rem_r    <= {WIDTH{1'b0}};
                        quo_r    <= acc_mag_s;
                        dvs_r    <= opd_mag_s;
                        cnt_r    <= CNT_W'(WIDTH - 1);
                        is_mod_r <= (req_op == 4'd4);
                        q_neg_r  <= acc_o[WIDTH-1] ^ req_operand[WIDTH-1];
                        r_neg_r  <= acc_o[WIDTH-1];
                        state_r  <= ST_DIV;
`else
                        state_r  <= ST_IDLE;
`endif
                    end else if (accept_s) begin
                        if (!alu_err_s) begin
                            acc_o <= alu_res_s;
                        end else begin
                            acc_o <= acc_o;
                        end
                        rsp_acc   <= alu_res_s;
                        rsp_err   <= alu_err_s;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RSP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_RSP;
                    end
                end
`ifdef COMPOUND_ASSIGN_DIV_EN
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        acc_o     <= div_res_s;
                        rsp_acc   <= div_res_s;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RSP;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compound_assign_unit.sv
// Self-checking bench for compound_assign_unit (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences, then randomized ops against a model.
module tb_compound_assign_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [W-1:0]  req_operand;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_acc;
    logic          rsp_err;
    logic [W-1:0]  acc_o;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] b;
        logic [W-1:0] exp_acc;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t tbl[$];

    compound_assign_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_operand (req_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_acc     (rsp_acc),
        .rsp_err     (rsp_err),
        .acc_o       (acc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [3:0] op, input logic [W-1:0] b,
                                    input logic [W-1:0] acc, input logic err, input int lat);
        vec_t v;
        v.op = op; v.b = b; v.exp_acc = acc; v.exp_err = err; v.exp_lat = lat;
        tbl.push_back(v);
    endfunction

    // Reference: plain 64-bit signed arithmetic applied to the operator rules.
    function automatic void ref_op(input logic [W-1:0] a, input logic [3:0] op, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic e, output int lat);
        longint sa, sb;
        int     amt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = (b > 32'd63) ? 63 : int'(b);
        r   = a;
        e   = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = W'(sa + sb);
            4'd1:  r = W'(sa - sb);
            4'd2:  r = W'(sa * sb);
            4'd3, 4'd4: begin
`ifdef COMPOUND_ASSIGN_DIV_EN
                if (sb == 0) e = 1'b1;
                else begin
                    r   = (op == 4'd3) ? W'(sa / sb) : W'(sa % sb);
                    lat = W + 1;
                end
`else
                e = 1'b1;
`endif
            end
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8, 4'd9: r = W'(sa << amt);
            4'd10: r = W'({32'd0, a} >> amt);
            4'd11: r = W'(sa >>> amt);
            4'd12: r = b;
            default: e = 1'b1;
        endcase
        if (e) r = a;
    endfunction

    // Issue one request, wait (bounded) for the response, then consume it.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] b,
                         output logic [W-1:0] acc, output logic err, output int lat);
        @(negedge clk);
        req_valid   = 1'b1;
        req_op      = op;
        req_operand = b;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            lat = lat + 1;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout: op %0d no response after %0d cycles", op, lat);
        end
        acc = rsp_acc;
        err = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_checked(input string name, input logic [3:0] op, input logic [W-1:0] b,
                               input logic [W-1:0] exp_acc, input logic exp_err, input int exp_lat);
        logic [W-1:0] got_acc;
        logic         got_err;
        int           got_lat;
        do_op(op, b, got_acc, got_err, got_lat);
        check({name, " rsp_acc"}, got_acc, exp_acc);
        check({name, " rsp_err"}, W'(got_err), W'(exp_err));
        check({name, " latency"}, W'(got_lat), W'(exp_lat));
        check({name, " acc_o"}, acc_o, exp_acc);
    endtask

    initial begin
        logic [W-1:0] m_acc, e_acc, b;
        logic         e_err;
        logic [3:0]   op;
        int           e_lat;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_operand = '0; rsp_ready = 1'b0;

        // Directed table: sequences from reset, each row uses the accumulator left by the previous one.
        add_vec(4'd12, 32'd5,        32'd5,        1'b0, 1);
        add_vec(4'd0,  32'd7,        32'd12,       1'b0, 1);
        add_vec(4'd1,  32'd20,       32'hFFFFFFF8, 1'b0, 1);
        add_vec(4'd12, 32'hFFFFFFF9, 32'hFFFFFFF9, 1'b0, 1);
`ifdef COMPOUND_ASSIGN_DIV_EN
        add_vec(4'd3,  32'd2,        32'hFFFFFFFD, 1'b0, 33);
        add_vec(4'd12, 32'hFFFFFFF9, 32'hFFFFFFF9, 1'b0, 1);
        add_vec(4'd4,  32'd2,        32'hFFFFFFFF, 1'b0, 33);
        add_vec(4'd12, 32'h80000000, 32'h80000000, 1'b0, 1);
        add_vec(4'd3,  32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
        add_vec(4'd4,  32'hFFFFFFFF, 32'h00000000, 1'b0, 33);
        add_vec(4'd12, 32'd100,      32'd100,      1'b0, 1);
        add_vec(4'd3,  32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33);
`else
        add_vec(4'd3,  32'd2,        32'hFFFFFFF9, 1'b1, 1);
        add_vec(4'd4,  32'd2,        32'hFFFFFFF9, 1'b1, 1);
        add_vec(4'd12, 32'h80000000, 32'h80000000, 1'b0, 1);
        add_vec(4'd3,  32'hFFFFFFFF, 32'h80000000, 1'b1, 1);
`endif
        add_vec(4'd12, 32'd9001,     32'd9001,     1'b0, 1);
        add_vec(4'd3,  32'd0,        32'd9001,     1'b1, 1);
        add_vec(4'd4,  32'd0,        32'd9001,     1'b1, 1);
        add_vec(4'd14, 32'd3,        32'd9001,     1'b1, 1);
        add_vec(4'd2,  32'd3,        32'd27003,    1'b0, 1);
        add_vec(4'd5,  32'h000000FF, 32'h0000007B, 1'b0, 1);
        add_vec(4'd6,  32'h00000100, 32'h0000017B, 1'b0, 1);
        add_vec(4'd7,  32'h00000003, 32'h00000178, 1'b0, 1);
        add_vec(4'd12, 32'h80000000, 32'h80000000, 1'b0, 1);
        add_vec(4'd11, 32'd4,        32'hF8000000, 1'b0, 1);
        add_vec(4'd12, 32'h80000000, 32'h80000000, 1'b0, 1);
        add_vec(4'd10, 32'd4,        32'h08000000, 1'b0, 1);
        add_vec(4'd8,  32'd40,       32'h00000000, 1'b0, 1);
        add_vec(4'd12, 32'h80000000, 32'h80000000, 1'b0, 1);
        add_vec(4'd11, 32'd40,       32'hFFFFFFFF, 1'b0, 1);
        add_vec(4'd9,  32'd1,        32'hFFFFFFFE, 1'b0, 1);
        add_vec(4'd10, 32'd31,       32'h00000001, 1'b0, 1);
        add_vec(4'd15, 32'd0,        32'h00000001, 1'b1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", W'(rsp_valid), '0);
        check("reset acc_o", acc_o, '0);
        check("reset rsp_acc", rsp_acc, '0);
        check("reset rsp_err", W'(rsp_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset req_ready", W'(req_ready), W'(1));

        foreach (tbl[i]) begin
            run_checked($sformatf("vec%0d", i), tbl[i].op, tbl[i].b,
                        tbl[i].exp_acc, tbl[i].exp_err, tbl[i].exp_lat);
        end

        // Back-pressure: response held, busy unit ignores a new request.
        run_checked("bp load", 4'd12, 32'd10, 32'd10, 1'b0, 1);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_operand = 32'd5;
        @(posedge clk);
        #1;
        req_op = 4'd12; req_operand = 32'd999;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid", W'(rsp_valid), W'(1));
            check("bp rsp_acc", rsp_acc, 32'd15);
            check("bp req_ready", W'(req_ready), '0);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp done rsp_valid", W'(rsp_valid), '0);
        check("bp done req_ready", W'(req_ready), W'(1));
        check("bp ignored req", acc_o, 32'd15);

        // Reset asserted while a divide (or, without the divider, a response) is pending.
        run_checked("rst load", 4'd12, 32'd100, 32'd100, 1'b0, 1);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd3; req_operand = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
`ifdef COMPOUND_ASSIGN_DIV_EN
        check("mid-div rsp_valid", W'(rsp_valid), '0);
`endif
        rst_n = 1'b0;
        #1;
        check("async rst rsp_valid", W'(rsp_valid), '0);
        check("async rst req_ready", W'(req_ready), W'(1));
        check("async rst acc_o", acc_o, '0);
        check("async rst rsp_acc", rsp_acc, '0);
        check("async rst rsp_err", W'(rsp_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("aborted no rsp", W'(rsp_valid), '0);
        run_checked("post-rst load", 4'd12, 32'd42, 32'd42, 1'b0, 1);

        // Randomized ops against the reference model.
        m_acc = 32'd42;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 40));
                2:       b = 32'd0;
                3:       b = 32'hFFFFFFFF;
                default: b = 32'h80000000;
            endcase
            if ($urandom_range(0, 5) == 0) op = 4'd12;
            ref_op(m_acc, op, b, e_acc, e_err, e_lat);
            run_checked($sformatf("rand%0d op%0d", i, op), op, b, e_acc, e_err, e_lat);
            m_acc = e_acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
